// File: rtl/ms_ctrl.sv
//============================================================================
// Module   : ms_ctrl
// Function : 15x15 maze-solver sequencer. Loads the maze, screens entry/exit,
//            starts the core and drains its path. Define MS_TIMEOUT_EN to
//            build the optional solver watchdog.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module ms_ctrl #(
  parameter int TIMEOUT_CYC = 900
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        maze,
  input  logic [3:0]  map_rd_row,
  output logic [14:0] map_rd_data,
  output logic        solve_start,
  output logic        solve_abort,
  input  logic        solve_done,
  input  logic        solve_fail,
  input  logic        path_empty,
  input  logic [3:0]  path_x,
  input  logic [3:0]  path_y,
  output logic        path_pop,
  output logic        out_valid,
  output logic        maze_not_valid,
  output logic [3:0]  out_x,
  output logic [3:0]  out_y
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SOLVE = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [3:0] c_last = 4'd14;

  state_t      r_state, w_state_next;
  logic [14:0] r_map [0:14];
  logic [3:0]  r_x, r_y, w_x_next, w_y_next, w_wr_x, w_wr_y;
  logic        w_wr_en;
  logic        r_start, r_abort, r_mnv, r_out_valid;
  logic [3:0]  r_out_x, r_out_y;
  logic        w_start_next, w_abort_next, w_mnv_next, w_out_valid_next;
  logic [3:0]  w_out_x_next, w_out_y_next;
  logic        w_tmo_hit;

`ifdef MS_TIMEOUT_EN
  logic [9:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_start_next) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_SOLVE) begin
      r_tmo_cnt <= r_tmo_cnt + 10'd1;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == 10'(TIMEOUT_CYC));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC == 0);
  assign w_tmo_hit    = 1'b0;
`endif

  // Row 15 is outside the maze and reads as solid wall.
  assign map_rd_data = (map_rd_row > c_last) ? 15'h7FFF : r_map[map_rd_row];

  always_comb begin
    w_state_next     = r_state;
    w_x_next         = r_x;
    w_y_next         = r_y;
    w_wr_en          = 1'b0;
    w_wr_x           = r_x;
    w_wr_y           = r_y;
    w_start_next     = 1'b0;
    w_abort_next     = 1'b0;
    w_mnv_next       = 1'b0;
    w_out_valid_next = 1'b0;
    w_out_x_next     = 4'd0;
    w_out_y_next     = 4'd0;
    path_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_wr_en      = 1'b1;
          w_wr_x       = 4'd0;
          w_wr_y       = 4'd0;
          w_x_next     = 4'd1;
          w_y_next     = 4'd0;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!in_valid) begin
          w_state_next = S_IDLE;
        end else begin
          w_wr_en = 1'b1;
          if (r_x == c_last) begin
            w_x_next = 4'd0;
            if (r_y == c_last) w_state_next = S_CHECK;
            else               w_y_next     = r_y + 4'd1;
          end else begin
            w_x_next = r_x + 4'd1;
          end
        end
      end
      S_CHECK: begin
        if (r_map[0][0] || r_map[14][14]) begin
          w_mnv_next   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_start_next = 1'b1;
          w_state_next = S_SOLVE;
        end
      end
      S_SOLVE: begin
        // Core results outrank the watchdog when they coincide.
        if (solve_fail) begin
          w_mnv_next   = 1'b1;
          w_state_next = S_IDLE;
        end else if (solve_done) begin
          w_state_next = S_DRAIN;
        end else if (w_tmo_hit) begin
          w_abort_next = 1'b1;
          w_mnv_next   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!path_empty) begin
          path_pop         = 1'b1;
          w_out_valid_next = 1'b1;
          w_out_x_next     = path_x;
          w_out_y_next     = path_y;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= 4'd0;
      r_y         <= 4'd0;
      r_start     <= 1'b0;
      r_abort     <= 1'b0;
      r_mnv       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_x     <= 4'd0;
      r_out_y     <= 4'd0;
    end else begin
      r_state     <= w_state_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_start     <= w_start_next;
      r_abort     <= w_abort_next;
      r_mnv       <= w_mnv_next;
      r_out_valid <= w_out_valid_next;
      r_out_x     <= w_out_x_next;
      r_out_y     <= w_out_y_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 15; r++) r_map[r] <= '0;
    end else if (w_wr_en) begin
      r_map[w_wr_y][w_wr_x] <= maze;
    end
  end

  assign solve_start    = r_start;
  assign solve_abort    = r_abort;
  assign maze_not_valid = r_mnv;
  assign out_valid      = r_out_valid;
  assign out_x          = r_out_x;
  assign out_y          = r_out_y;

endmodule

`default_nettype wire

// File: tb/tb_ms_ctrl.sv
//============================================================================
// Module   : tb_ms_ctrl
// Function : Self-checking bench for ms_ctrl with a behavioural maze/path
//            model and a FIFO stand-in for the solver core.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ms_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        maze = 1'b0;
  logic [3:0]  map_rd_row = 4'd0;
  logic [14:0] map_rd_data;
  logic        solve_start, solve_abort, path_pop, out_valid, maze_not_valid;
  logic        solve_done = 1'b0;
  logic        solve_fail = 1'b0;
  logic        path_empty = 1'b1;
  logic [3:0]  path_x = 4'd0;
  logic [3:0]  path_y = 4'd0;
  logic [3:0]  out_x, out_y;

  int errors = 0;
  int checks = 0;
  int mnv_cnt = 0, start_cnt = 0, ov_cnt = 0, abort_cnt = 0, pop_cnt = 0;

  bit         m [225];
  logic [7:0] fifo_q [$];
  logic [7:0] exp_path [$];

  ms_ctrl #(.TIMEOUT_CYC(900)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .maze(maze),
    .map_rd_row(map_rd_row), .map_rd_data(map_rd_data),
    .solve_start(solve_start), .solve_abort(solve_abort),
    .solve_done(solve_done), .solve_fail(solve_fail),
    .path_empty(path_empty), .path_x(path_x), .path_y(path_y),
    .path_pop(path_pop), .out_valid(out_valid),
    .maze_not_valid(maze_not_valid), .out_x(out_x), .out_y(out_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First-word-fall-through path FIFO standing in for the core.
  always @(posedge clk) begin
    if (path_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    path_empty <= (fifo_q.size() == 0);
    path_x     <= (fifo_q.size() != 0) ? fifo_q[0][7:4] : 4'd0;
    path_y     <= (fifo_q.size() != 0) ? fifo_q[0][3:0] : 4'd0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (maze_not_valid) mnv_cnt++;
      if (solve_start)    start_cnt++;
      if (out_valid)      ov_cnt++;
      if (solve_abort)    abort_cnt++;
      if (path_pop)       pop_cnt++;
      chk("mnv_ov_exclusive", 32'(maze_not_valid & out_valid), 32'd0);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_maze(input bit open_corners);
    for (int i = 0; i < 225; i++) m[i] = ($urandom_range(0, 3) == 0);
    if (open_corners) begin
      m[0]   = 1'b0;
      m[224] = 1'b0;
    end
  endtask

  task automatic drive_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      maze     = m[i];
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    maze     = 1'b0;
  endtask

  task automatic check_rows(input string tag);
    logic [14:0] exp_row;
    for (int r = 0; r < 16; r++) begin
      map_rd_row = 4'(r);
      #1;
      exp_row = 15'h7FFF;
      if (r < 15) for (int x = 0; x < 15; x++) exp_row[x] = m[r * 15 + x];
      chk(tag, 32'(map_rd_data), 32'(exp_row));
    end
  endtask

  // Called right after drive_bits returns a full load (cycle N+1).
  task automatic expect_outcome(input bit blocked);
    @(negedge clk);
    chk("check_cycle_quiet", 32'({solve_start, maze_not_valid}), 32'd0);
    @(negedge clk);
    chk("start_at_n2", 32'(solve_start), 32'(!blocked));
    chk("mnv_at_n2", 32'(maze_not_valid), 32'(blocked));
    @(negedge clk);
    chk("pulse_one_cycle", 32'({solve_start, maze_not_valid}), 32'd0);
  endtask

  task automatic make_path(input bit straight);
    int x, y;
    x = 0;
    y = 0;
    exp_path.delete();
    exp_path.push_back(8'h00);
    while (!(x == 14 && y == 14)) begin
      if (x < 14 && (straight || y == 14 || $urandom_range(0, 1) == 1)) x++;
      else y++;
      exp_path.push_back({4'(x), 4'(y)});
    end
  endtask

  task automatic done_and_drain();
    int ov0;
    ov0 = ov_cnt;
    foreach (exp_path[i]) fifo_q.push_back(exp_path[i]);
    tick();
    solve_done = 1'b1;
    tick();
    solve_done = 1'b0;
    @(negedge clk);
    chk("drain_first_cycle_idle", 32'(out_valid), 32'd0);
    foreach (exp_path[i]) begin
      @(negedge clk);
      chk("path_valid", 32'(out_valid), 32'd1);
      chk("path_xy", 32'({out_x, out_y}), 32'(exp_path[i]));
    end
    @(negedge clk);
    chk("drain_end_zero", 32'({out_valid, out_x, out_y}), 32'd0);
    tick();
    chk("path_len", 32'(ov_cnt - ov0), 32'(exp_path.size()));
  endtask

  initial begin
    int s0, m0, o0, p0, a0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 32'({out_valid, maze_not_valid, solve_start, solve_abort,
                         path_pop, out_x, out_y}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 225; i++) m[i] = 1'b0;
    check_rows("rst_rows");

    // Open maze, straight 29-entry path
    drive_bits(225);
    expect_outcome(1'b0);
    map_rd_row = 4'd7;
    #1;
    chk("open_row7", 32'(map_rd_data), 32'd0);
    make_path(1'b1);
    chk("path_model_len", 32'(exp_path.size()), 32'd29);
    done_and_drain();

    // Blocked entry, then blocked exit
    for (int k = 0; k < 2; k++) begin
      s0 = start_cnt; o0 = ov_cnt;
      gen_maze(1'b1);
      if (k == 0) m[0] = 1'b1; else m[224] = 1'b1;
      drive_bits(225);
      expect_outcome(1'b1);
      check_rows("blocked_rows");
      tick();
      chk("blocked_no_start", 32'(start_cnt - s0), 32'd0);
      chk("blocked_no_out", 32'(ov_cnt - o0), 32'd0);
    end

    // Early drop after 100 bits, then a full random load and random path
    s0 = start_cnt; m0 = mnv_cnt; o0 = ov_cnt;
    gen_maze(1'b1);
    drive_bits(100);
    repeat (5) tick();
    chk("drop_quiet", 32'((start_cnt - s0) + (mnv_cnt - m0) + (ov_cnt - o0)), 32'd0);
    for (int k = 0; k < 2; k++) begin
      gen_maze(1'b1);
      drive_bits(225);
      expect_outcome(1'b0);
      check_rows("rand_rows");
      make_path(1'b0);
      done_and_drain();
    end

    // Fail alone, then done+fail together: fail wins, nothing popped
    for (int k = 0; k < 2; k++) begin
      gen_maze(1'b1);
      drive_bits(225);
      expect_outcome(1'b0);
      make_path(1'b0);
      foreach (exp_path[i]) fifo_q.push_back(exp_path[i]);
      p0 = pop_cnt; m0 = mnv_cnt;
      tick();
      solve_fail = 1'b1;
      solve_done = (k == 1);
      tick();
      solve_fail = 1'b0;
      solve_done = 1'b0;
      @(negedge clk);
      chk("fail_mnv", 32'({maze_not_valid, out_valid}), 32'b10);
      @(negedge clk);
      chk("fail_mnv_once", 32'(maze_not_valid), 32'd0);
      repeat (3) tick();
      chk("fail_no_pop", 32'(pop_cnt - p0), 32'd0);
      chk("fail_mnv_count", 32'(mnv_cnt - m0), 32'd1);
      fifo_q.delete();
      tick();
    end

    // Reset during a load discards the partial maze
    gen_maze(1'b0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      maze     = m[i];
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 225; i++) m[i] = 1'b0;
    check_rows("midreset_rows");

    // Silent core: watchdog behaviour
    gen_maze(1'b1);
    drive_bits(225);
    expect_outcome(1'b0);
    a0 = abort_cnt; m0 = mnv_cnt;
`ifdef MS_TIMEOUT_EN
    repeat (899) @(negedge clk);
    chk("tmo_not_early", 32'({solve_abort, maze_not_valid}), 32'd0);
    @(negedge clk);
    chk("tmo_pulse", 32'({solve_abort, maze_not_valid}), 32'b11);
    @(negedge clk);
    chk("tmo_pulse_once", 32'({solve_abort, maze_not_valid}), 32'd0);
    tick();
    chk("tmo_counts", 32'((abort_cnt - a0) + (mnv_cnt - m0)), 32'd2);
`else
    repeat (2000) tick();
    chk("no_tmo_abort", 32'(abort_cnt - a0), 32'd0);
    chk("no_tmo_mnv", 32'(mnv_cnt - m0), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
